// File: rtl/instruction_fetch_unit.sv
// RV32IM instruction fetch: PC, busywait memory handshake, IF/ID register, stall/redirect handling.
// Optional performance counters are enabled with `define IFU_PERF_COUNTERS_EN.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic        CLK,
    input  logic        RESET,
    output logic [31:0] IMEM_ADDRESS,
    output logic        IMEM_READ,
    input  logic [31:0] IMEM_READDATA,
    input  logic        IMEM_BUSYWAIT,
    input  logic        STALL,
    input  logic        BRANCH_TAKEN,
    input  logic [31:0] BRANCH_TARGET,
    output logic [31:0] INSTRUCTION,
    output logic [31:0] PC,
    output logic [31:0] PC_PLUS4,
    output logic        VALID
`ifdef IFU_PERF_COUNTERS_EN
    ,
    output logic [31:0] FETCH_COUNT,
    output logic [31:0] BUBBLE_COUNT
`endif
);

    localparam logic [31:0] NOP = 32'h00000013;

    typedef enum logic [1:0] {
        FETCH,
        DISCARD,
        BUFFERED
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] target_reg, target_next;
    logic [31:0] skid_reg, skid_next;
    logic [31:0] instr_reg, instr_next;
    logic [31:0] ifid_pc_reg, ifid_pc_next;
    logic [31:0] ifid_pc4_reg, ifid_pc4_next;
    logic        valid_reg, valid_next;
    logic        ifid_load;
    logic        done;
    logic [31:0] pc_plus4;
    logic [31:0] discard_target;

    assign pc_plus4     = pc_reg + 32'd4;
    // DISCARD keeps the old PC on the bus so the outstanding request is never withdrawn
    assign IMEM_ADDRESS = pc_reg;
    assign IMEM_READ    = !RESET && (state_reg != BUFFERED);
    assign done         = IMEM_READ && !IMEM_BUSYWAIT;
    assign discard_target = BRANCH_TAKEN ? BRANCH_TARGET : target_reg;

    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        target_next   = target_reg;
        skid_next     = skid_reg;
        instr_next    = instr_reg;
        ifid_pc_next  = ifid_pc_reg;
        ifid_pc4_next = ifid_pc4_reg;
        valid_next    = valid_reg;
        ifid_load     = 1'b0;

        case (state_reg)
            FETCH: begin
                if (BRANCH_TAKEN) begin
                    ifid_load  = 1'b1;
                    instr_next = NOP;
                    valid_next = 1'b0;
                    if (done) begin
                        pc_next = BRANCH_TARGET;
                    end else begin
                        target_next = BRANCH_TARGET;
                        state_next  = DISCARD;
                    end
                end else if (done) begin
                    if (!STALL) begin
                        ifid_load     = 1'b1;
                        instr_next    = IMEM_READDATA;
                        ifid_pc_next  = pc_reg;
                        ifid_pc4_next = pc_plus4;
                        valid_next    = 1'b1;
                        pc_next       = pc_plus4;
                    end else begin
                        skid_next  = IMEM_READDATA;
                        state_next = BUFFERED;
                    end
                end else if (!STALL) begin
                    ifid_load  = 1'b1;
                    instr_next = NOP;
                    valid_next = 1'b0;
                end
            end
            DISCARD: begin
                target_next = discard_target;
                if (done) begin
                    pc_next    = discard_target;
                    state_next = FETCH;
                end
                if (BRANCH_TAKEN || !STALL) begin
                    ifid_load  = 1'b1;
                    instr_next = NOP;
                    valid_next = 1'b0;
                end
            end
            BUFFERED: begin
                if (BRANCH_TAKEN) begin
                    ifid_load  = 1'b1;
                    instr_next = NOP;
                    valid_next = 1'b0;
                    pc_next    = BRANCH_TARGET;
                    state_next = FETCH;
                end else if (!STALL) begin
                    ifid_load     = 1'b1;
                    instr_next    = skid_reg;
                    ifid_pc_next  = pc_reg;
                    ifid_pc4_next = pc_plus4;
                    valid_next    = 1'b1;
                    pc_next       = pc_plus4;
                    state_next    = FETCH;
                end
            end
            default: begin
                state_next = FETCH;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg    <= FETCH;
            pc_reg       <= RESET_PC;
            target_reg   <= 32'd0;
            skid_reg     <= 32'd0;
            instr_reg    <= NOP;
            ifid_pc_reg  <= 32'd0;
            ifid_pc4_reg <= 32'd0;
            valid_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            pc_reg     <= pc_next;
            target_reg <= target_next;
            skid_reg   <= skid_next;
            if (ifid_load) begin
                instr_reg    <= instr_next;
                ifid_pc_reg  <= ifid_pc_next;
                ifid_pc4_reg <= ifid_pc4_next;
                valid_reg    <= valid_next;
            end
        end
    end

    assign INSTRUCTION = instr_reg;
    assign PC          = ifid_pc_reg;
    assign PC_PLUS4    = ifid_pc4_reg;
    assign VALID       = valid_reg;

`ifdef IFU_PERF_COUNTERS_EN
    logic [31:0] fetch_count_reg;
    logic [31:0] bubble_count_reg;

    // Stall-hold cycles do not load IF/ID, so they are not counted
    always_ff @(posedge CLK) begin
        if (RESET) begin
            fetch_count_reg  <= 32'd0;
            bubble_count_reg <= 32'd0;
        end else if (ifid_load) begin
            if (valid_next) begin
                fetch_count_reg <= fetch_count_reg + 32'd1;
            end else begin
                bubble_count_reg <= bubble_count_reg + 32'd1;
            end
        end
    end

    assign FETCH_COUNT  = fetch_count_reg;
    assign BUBBLE_COUNT = bubble_count_reg;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed test-plan steps then randomized traffic
// checked against a queue-based behavioural model.
module tb_instruction_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h00000100;
    localparam logic [31:0] NOP    = 32'h00000013;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [31:0] IMEM_ADDRESS;
    logic        IMEM_READ;
    logic [31:0] IMEM_READDATA = 32'd0;
    logic        IMEM_BUSYWAIT = 1'b0;
    logic        STALL = 1'b0;
    logic        BRANCH_TAKEN = 1'b0;
    logic [31:0] BRANCH_TARGET = 32'd0;
    logic [31:0] INSTRUCTION;
    logic [31:0] PC;
    logic [31:0] PC_PLUS4;
    logic        VALID;
`ifdef IFU_PERF_COUNTERS_EN
    logic [31:0] FETCH_COUNT;
    logic [31:0] BUBBLE_COUNT;
`endif

    instruction_fetch_unit #(.RESET_PC(RST_PC)) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .IMEM_ADDRESS (IMEM_ADDRESS),
        .IMEM_READ    (IMEM_READ),
        .IMEM_READDATA(IMEM_READDATA),
        .IMEM_BUSYWAIT(IMEM_BUSYWAIT),
        .STALL        (STALL),
        .BRANCH_TAKEN (BRANCH_TAKEN),
        .BRANCH_TARGET(BRANCH_TARGET),
        .INSTRUCTION  (INSTRUCTION),
        .PC           (PC),
        .PC_PLUS4     (PC_PLUS4),
        .VALID        (VALID)
`ifdef IFU_PERF_COUNTERS_EN
        ,
        .FETCH_COUNT  (FETCH_COUNT),
        .BUBBLE_COUNT (BUBBLE_COUNT)
`endif
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Behavioural model: program counter, an optional pending redirect, and a skid queue of 0/1 words
    logic [31:0] m_pc, m_tgt, m_instr, m_ifpc, m_ifpc4, m_fetch, m_bubble;
    logic        m_valid, m_discard;
    logic [31:0] m_skid[$];

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h0F0F_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic m_load_bubble();
        m_instr = NOP;
        m_valid = 1'b0;
        m_bubble++;
    endtask

    task automatic m_load_word(input logic [31:0] w);
        m_instr = w;
        m_ifpc  = m_pc;
        m_ifpc4 = m_pc + 32'd4;
        m_valid = 1'b1;
        m_fetch++;
        m_pc    = m_pc + 32'd4;
    endtask

    task automatic check_ifid();
        chk("instruction", INSTRUCTION, m_instr);
        chk("pc", PC, m_ifpc);
        chk("pc_plus4", PC_PLUS4, m_ifpc4);
        chk("valid", {31'd0, VALID}, {31'd0, m_valid});
`ifdef IFU_PERF_COUNTERS_EN
        chk("fetch_count", FETCH_COUNT, m_fetch);
        chk("bubble_count", BUBBLE_COUNT, m_bubble);
`endif
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RESET = 1'b1;
        IMEM_BUSYWAIT = 1'b0;
        STALL = 1'b0;
        BRANCH_TAKEN = 1'b0;
        #1;
        chk("read_in_reset", {31'd0, IMEM_READ}, 32'd0);
        @(posedge CLK);
        m_pc = RST_PC;
        m_tgt = 32'd0;
        m_discard = 1'b0;
        m_skid.delete();
        m_instr = NOP;
        m_ifpc = 32'd0;
        m_ifpc4 = 32'd0;
        m_valid = 1'b0;
        m_fetch = 32'd0;
        m_bubble = 32'd0;
        #1;
        check_ifid();
        $display("RESET pc=%h valid=%0d", PC, VALID);
    endtask

    task automatic step(input logic busy, input logic stall, input logic br, input logic [31:0] tgt);
        logic exp_read;
        logic done;
        logic [31:0] data;
        @(negedge CLK);
        RESET = 1'b0;
        IMEM_BUSYWAIT = busy;
        STALL = stall;
        BRANCH_TAKEN = br;
        BRANCH_TARGET = tgt;
        IMEM_READDATA = word_of(IMEM_ADDRESS);
        data = word_of(m_pc);
        #1;
        exp_read = (m_skid.size() == 0);
        chk("imem_read", {31'd0, IMEM_READ}, {31'd0, exp_read});
        if (exp_read) chk("imem_address", IMEM_ADDRESS, m_pc);
        done = exp_read && !busy;
        @(posedge CLK);
        if (m_skid.size() != 0) begin
            if (br) begin
                m_skid.delete();
                m_pc = tgt;
                m_load_bubble();
            end else if (!stall) begin
                m_load_word(m_skid.pop_front());
            end
        end else if (m_discard) begin
            if (br) m_tgt = tgt;
            if (done) begin
                m_pc = m_tgt;
                m_discard = 1'b0;
            end
            if (br || !stall) m_load_bubble();
        end else begin
            if (br) begin
                m_load_bubble();
                if (done) m_pc = tgt;
                else begin
                    m_discard = 1'b1;
                    m_tgt = tgt;
                end
            end else if (done) begin
                if (!stall) m_load_word(data);
                else m_skid.push_back(data);
            end else if (!stall) begin
                m_load_bubble();
            end
        end
        #1;
        check_ifid();
        $display("STEP busy=%0d stall=%0d br=%0d tgt=%h -> instr=%h pc=%h pc4=%h valid=%0d",
                 busy, stall, br, tgt, INSTRUCTION, PC, PC_PLUS4, VALID);
    endtask

    initial begin
        do_reset();
        do_reset();

        // Zero-wait fetch from RESET_PC
        repeat (3) step(1'b0, 1'b0, 1'b0, 32'd0);
        chk("plan_pc_third", PC, 32'h108);
        chk("plan_pc4_third", PC_PLUS4, 32'h10C);
        chk("plan_instr_third", INSTRUCTION, word_of(32'h108));

        // Three-cycle busywait per fetch
        repeat (2) begin
            repeat (3) step(1'b1, 1'b0, 1'b0, 32'd0);
            step(1'b0, 1'b0, 1'b0, 32'd0);
        end

        // Redirect while a fetch is pending
        step(1'b1, 1'b0, 1'b1, 32'h200);
        step(1'b1, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'd0);
        chk("plan_redirect_pc", PC, 32'h200);

        // Completion under a two-cycle stall, then release
        step(1'b0, 1'b1, 1'b0, 32'd0);
        step(1'b0, 1'b1, 1'b0, 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'd0);
        chk("plan_skid_pc", PC, 32'h204);

        // Stall and redirect together while buffered
        step(1'b0, 1'b1, 1'b0, 32'd0);
        step(1'b0, 1'b1, 1'b1, 32'h300);
        step(1'b0, 1'b0, 1'b0, 32'd0);
        chk("plan_flush_pc", PC, 32'h300);

        // PC wrap at the top of the address space
        step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, 1'b0, 32'd0);
        chk("plan_wrap_pc4", PC_PLUS4, 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'd0);

        // Reset in the middle of a wait
        step(1'b1, 1'b0, 1'b0, 32'd0);
        do_reset();
        step(1'b0, 1'b0, 1'b0, 32'd0);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 2) == 0,
                     $urandom_range(0, 3) == 0,
                     $urandom_range(0, 7) == 0,
                     ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
